// File: rtl/conv_enc_k3_if.sv
// Stream bundle between the upstream bit source, the K=3 encoder and the
// downstream symbol sink. The encoder is the slave; the environment is the master.
interface conv_enc_k3_if;
  logic       in_bit;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [1:0] tx_pair;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  modport master (
    output in_bit, in_valid, in_last, out_ready,
    input  in_ready, tx_pair, out_valid, out_last
  );

  modport slave (
    input  in_bit, in_valid, in_last, out_ready,
    output in_ready, tx_pair, out_valid, out_last
  );
endinterface

// File: rtl/conv_enc_k3.sv
// Rate-1/2, K=3 convolutional encoder with automatic two-bit zero tail per frame
// and a single-entry output register sustaining one symbol per cycle.
module conv_enc_k3 #(
  parameter logic [2:0] G0 = 3'b111,
  parameter logic [2:0] G1 = 3'b101
) (
  input logic          clk,
  input logic          rst_n,
  conv_enc_k3_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_DATA = 2'b01;
  localparam logic [1:0] ST_TAIL = 2'b10;

  function automatic logic parity3(input logic [2:0] v);
    return ^v;
  endfunction

  // Window ordering: bit 2 = bit being encoded, bit 1 = sr[0], bit 0 = sr[1].
  function automatic logic [1:0] encode(input logic [2:0] window);
    return {parity3(G0 & window), parity3(G1 & window)};
  endfunction

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [1:0] sr_r;
  logic [1:0] sr_nxt_s;
  logic       tail_cnt_r;
  logic       tail_cnt_nxt_s;
  logic [1:0] tx_pair_r;
  logic       out_valid_r;
  logic       out_last_r;
  logic       slot_free_s;
  logic       in_ready_s;
  logic       load_s;
  logic       load_last_s;
  logic       enc_bit_s;
  logic [2:0] window_s;
  logic [1:0] code_s;

  // Handshake qualifiers; in_ready is forced low while reset is held.
  always_comb begin
    slot_free_s = !out_valid_r || bus.out_ready;
    in_ready_s  = rst_n && slot_free_s && (state_r != ST_TAIL);
  end

  // Frame sequencing: select the bit to encode and compute next state/shift register.
  always_comb begin
    state_nxt_s    = state_r;
    sr_nxt_s       = sr_r;
    tail_cnt_nxt_s = tail_cnt_r;
    load_s         = 1'b0;
    load_last_s    = 1'b0;
    enc_bit_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_DATA: begin
        if (bus.in_valid && in_ready_s) begin
          load_s    = 1'b1;
          enc_bit_s = bus.in_bit;
          sr_nxt_s  = {sr_r[0], bus.in_bit};
          if (bus.in_last) begin
            state_nxt_s    = ST_TAIL;
            tail_cnt_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_TAIL: begin
        if (slot_free_s) begin
          load_s    = 1'b1;
          enc_bit_s = 1'b0;
          if (tail_cnt_r) begin
            // Second flush bit terminates the trellis; state 0 is enforced.
            load_last_s    = 1'b1;
            state_nxt_s    = ST_IDLE;
            sr_nxt_s       = 2'b00;
            tail_cnt_nxt_s = 1'b0;
          end else begin
            sr_nxt_s       = {sr_r[0], 1'b0};
            tail_cnt_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        sr_nxt_s       = 2'b00;
        tail_cnt_nxt_s = 1'b0;
      end
    endcase
  end

  // Generator-polynomial evaluation over the current window.
  always_comb begin
    window_s = {enc_bit_s, sr_r[0], sr_r[1]};
    code_s   = encode(window_s);
  end

  // Encoder state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      sr_r       <= 2'b00;
      tail_cnt_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      sr_r       <= sr_nxt_s;
      tail_cnt_r <= tail_cnt_nxt_s;
    end
  end

  // Single-entry output slot: holds while stalled, refills or empties when free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_pair_r   <= 2'b00;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (slot_free_s) begin
      if (load_s) begin
        tx_pair_r   <= code_s;
        out_valid_r <= 1'b1;
        out_last_r  <= load_last_s;
      end else begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end else begin
      tx_pair_r   <= tx_pair_r;
      out_valid_r <= out_valid_r;
      out_last_r  <= out_last_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.tx_pair   = tx_pair_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_conv_enc_k3.sv
// Scoreboarded bench for conv_enc_k3: directed frames with literal expectations
// plus random frames checked against a tap-equation reference model.
module tb_conv_enc_k3;
  typedef logic bitq_t[$];

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_enc_k3_if bus ();
  conv_enc_k3 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] exp_q[$];          // {tx_pair, out_last}
  logic [2:0] exp_sym;
  logic       held_v = 1'b0;
  logic [2:0] held_sym;
  int         ready_mode = 0;    // 0 always ready, 1 fixed pattern, 2 random
  int         pat_idx = 0;
  logic       pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Downstream ready generator.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: begin
        bus.out_ready = pat[pat_idx % 6];
        pat_idx++;
      end
      default: bus.out_ready = ($urandom_range(0, 99) < 65);
    endcase
  end

  // Monitor: pops the scoreboard on every transfer, and checks stalled symbols hold.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (held_v) check("stall_hold", {bus.tx_pair, bus.out_last}, held_sym);
      if (bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_symbol");
        end else begin
          exp_sym = exp_q.pop_front();
          check("symbol", {bus.tx_pair, bus.out_last}, exp_sym);
        end
        held_v = 1'b0;
      end else begin
        held_v   = 1'b1;
        held_sym = {bus.tx_pair, bus.out_last};
      end
    end else begin
      if (rst_n === 1'b1 && held_v) fail_now("stall_valid_drop");
      held_v = 1'b0;
    end
  end

  function automatic logic ubit(bitq_t u, int i);
    return (i >= 0 && i < u.size()) ? u[i] : 1'b0;
  endfunction

  // Reference: c_hi = u[k]^u[k-1]^u[k-2], c_lo = u[k]^u[k-2], two zero tail bits appended.
  task automatic push_model(bitq_t u);
    int n = u.size();
    for (int k = 0; k < n + 2; k++) begin
      logic hi, lo;
      hi = ubit(u, k) ^ ubit(u, k - 1) ^ ubit(u, k - 2);
      lo = ubit(u, k) ^ ubit(u, k - 2);
      exp_q.push_back({hi, lo, (k == n + 1) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic drive_bit(input logic b, input logic last);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_last  = last;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 200) fail_now("in_ready_timeout");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(bitq_t u, input logic use_model);
    if (use_model) push_model(u);
    foreach (u[i]) drive_bit(u[i], (i == u.size() - 1) ? 1'b1 : 1'b0);
    @(negedge clk);
    check("in_ready_tail", bus.in_ready, 1'b0);
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    check("idle_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bitq_t u;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_tx_pair", bus.tx_pair, 2'b00);
    check("rst_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic frame 1,0,1,1 at full rate.
    ready_mode = 0;
    exp_q = '{3'b110, 3'b100, 3'b000, 3'b010, 3'b010, 3'b111};
    u = '{1'b1, 1'b0, 1'b1, 1'b1};
    send_frame(u, 1'b0);
    drain();

    // Same frame under a fixed backpressure pattern.
    ready_mode = 1;
    pat_idx = 0;
    exp_q = '{3'b110, 3'b100, 3'b000, 3'b010, 3'b010, 3'b111};
    send_frame(u, 1'b0);
    drain();

    // Single-bit frame, then a zero frame proving the register was flushed.
    ready_mode = 0;
    exp_q = '{3'b110, 3'b100, 3'b111, 3'b000, 3'b000, 3'b001};
    u = '{1'b1};
    send_frame(u, 1'b0);
    u = '{1'b0};
    send_frame(u, 1'b0);
    drain();

    // Back-to-back frames 1,1 and 0,1.
    exp_q = '{3'b110, 3'b010, 3'b010, 3'b111, 3'b000, 3'b110, 3'b100, 3'b111};
    u = '{1'b1, 1'b1};
    send_frame(u, 1'b0);
    u = '{1'b0, 1'b1};
    send_frame(u, 1'b0);
    drain();

    // Asynchronous reset after two accepted bits.
    exp_q = '{3'b110, 3'b100};
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_out_last", bus.out_last, 1'b0);
    check("midrst_tx_pair", bus.tx_pair, 2'b00);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    exp_q.delete();
    held_v = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q = '{3'b110, 3'b100, 3'b111};
    u = '{1'b1};
    send_frame(u, 1'b0);
    drain();

    // All-zero frame of 8 bits.
    for (int i = 0; i < 9; i++) exp_q.push_back(3'b000);
    exp_q.push_back(3'b001);
    u = {};
    for (int i = 0; i < 8; i++) u.push_back(1'b0);
    send_frame(u, 1'b0);
    drain();

    // Random frames with random backpressure and idle gaps.
    ready_mode = 2;
    for (int f = 0; f < 25; f++) begin
      int len = $urandom_range(1, 12);
      u = {};
      for (int i = 0; i < len; i++) u.push_back(1'($urandom_range(0, 1)));
      send_frame(u, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
